// File: rtl/filter_demo.sv
// filter_demo: 16-tap direct-form FIR with fixed symmetric low-pass coefficients.
// The pipeline is delay line, then per-tap products, then the summed output.
// It is exact throughout, so the output needs no rounding.

// Per-tap signed multiplier: full-precision product of one tap and its coefficient.
module filter_demo_tap #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int PW = DW + CW
) (
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] sample,
    output logic signed [PW-1:0] prod
);
    // Both operands are signed, so they are sign-extended to PW before the multiply.
    always_comb begin
        prod = coef * sample;
    end
endmodule

module filter_demo #(
    parameter int TAPS = 16,
    parameter int DW   = 16,
    parameter int OW   = 65
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] a,
    output logic signed [OW-1:0] b
);
    localparam int CW = 16;
    localparam int PW = DW + CW;

    // Coefficient set; the filter is symmetric and the coefficients sum to 1550 (DC gain).
    localparam logic signed [CW-1:0] H [16] = '{
        16'sd3,   -16'sd8,   -16'sd20,  16'sd0,
        16'sd64,   16'sd160,  16'sd256, 16'sd320,
        16'sd320,  16'sd256,  16'sd160, 16'sd64,
        16'sd0,   -16'sd20,  -16'sd8,   16'sd3
    };

    logic [TAPS-1:0][DW-1:0] tap_q, tap_d;
    logic [TAPS-1:0][PW-1:0] prod_q, prod_d;
    logic signed [OW-1:0]    b_q, b_d;

    // Delay line: the newest sample enters tap 0 and older samples move up one tap.
    always_comb begin
        tap_d    = tap_q;
        tap_d[0] = a;
        for (int k = 1; k < TAPS; k++) begin
            tap_d[k] = tap_q[k-1];
        end
    end

    // One multiplier per tap, computing the next registered product.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic signed [PW-1:0] p;
        filter_demo_tap #(.DW(DW), .CW(CW), .PW(PW)) u_tap (
            .coef   (H[k]),
            .sample ($signed(tap_q[k])),
            .prod   (p)
        );
        assign prod_d[k] = p;
    end

    // Sum all registered products, sign-extending each product to the full output width.
    always_comb begin
        b_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            b_d = b_d + $signed({{(OW-PW){prod_q[k][PW-1]}}, prod_q[k]});
        end
    end

    // Pipeline registers; a synchronous reset clears the whole history.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q  <= '0;
            prod_q <= '0;
            b_q    <= '0;
        end else begin
            tap_q  <= tap_d;
            prod_q <= prod_d;
            b_q    <= b_d;
        end
    end

    assign b = b_q;
endmodule

// File: tb/tb_filter_demo.sv
// tb_filter_demo: scoreboard bench for filter_demo.
// Each driven edge pushes the reference convolution of the modelled delay line.
// The output after that edge is compared with the value pushed two edges earlier.
module tb_filter_demo;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] a   = '0;
    logic signed [64:0] b;

    int n_chk  = 0;
    int n_fail = 0;

    filter_demo #(.TAPS(16), .DW(16), .OW(65)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b)
    );

    always #5 clk = ~clk;

    longint             hc [16] = '{3, -8, -20, 0, 64, 160, 256, 320, 320, 256, 160, 64, 0, -20, -8, 3};
    longint             mt [16];
    logic signed [64:0] sb [$];

    task automatic chk(input string tag, input logic signed [64:0] got, input logic signed [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one edge, update the reference delay line and push the convolution.
    // After the edge, compare b with the oldest expected value.
    task automatic step(input logic r, input logic signed [15:0] x, input string tag);
        longint             acc;
        logic signed [64:0] e;
        rst = r;
        a   = x;
        @(posedge clk);
        if (r) begin
            foreach (mt[k]) mt[k] = 0;
            sb.delete();
            sb.push_back('0);
            sb.push_back('0);
        end else begin
            for (int k = 15; k > 0; k--) mt[k] = mt[k-1];
            mt[0] = longint'(x);
        end
        acc = 0;
        foreach (mt[k]) acc += hc[k] * mt[k];
        sb.push_back(65'(acc));
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, b, 'x);
        end else begin
            e = sb.pop_front();
            chk(tag, b, e);
        end
    endtask

    initial begin
        foreach (mt[k]) mt[k] = 0;

        // Reset state.
        step(1'b1, 16'sd0, "reset");
        step(1'b1, 16'sd555, "reset_hold");
        chk("reset_value", b, 65'sd0);

        // Impulse response, followed by zeros.
        step(1'b0, 16'sd1, "impulse");
        for (int i = 0; i < 20; i++) step(1'b0, 16'sd0, "impulse");

        // Step response.
        step(1'b1, 16'sd0, "reset");
        step(1'b0, 16'sd1, "step");
        step(1'b0, 16'sd1, "step");
        step(1'b0, 16'sd1, "step");
        chk("step_e2", b, 65'sd3);
        step(1'b0, 16'sd1, "step");
        chk("step_e3", b, -65'sd5);
        step(1'b0, 16'sd1, "step");
        chk("step_e4", b, -65'sd25);
        for (int i = 0; i < 20; i++) step(1'b0, 16'sd1, "step");
        chk("step_settle", b, 65'sd1550);

        // Positive extreme.
        for (int i = 0; i < 20; i++) step(1'b0, 16'sd32767, "max");
        chk("max_settle", b, 65'sd50788850);

        // Negative extreme.
        for (int i = 0; i < 20; i++) step(1'b0, -16'sd32768, "min");
        chk("min_settle", b, -65'sd50790400);

        // Reset in the middle of a stream.
        for (int i = 0; i < 20; i++) step(1'b0, 16'sd1000, "mid");
        step(1'b1, 16'sd1000, "mid_rst");
        chk("mid_rst_zero", b, 65'sd0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 16'sd0, "mid_after");
            chk("mid_after_zero", b, 65'sd0);
        end

        // Zero input.
        step(1'b1, 16'sd0, "reset");
        for (int i = 0; i < 200; i++) step(1'b0, 16'sd0, "zero");

        // Random samples, then zeros to flush the pipeline.
        for (int i = 0; i < 200; i++) step(1'b0, 16'($urandom()), "random");
        for (int i = 0; i < 20; i++) step(1'b0, 16'sd0, "flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
